instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  IF stage upstream of the instruction ROM. Holds the PC and drives the ROM byte address.
//  Registers the combinational 32-bit ROM word into the IF/ID pipeline register with its PC
//  and a valid flag. Honours stall and branch/jump redirect requests from ID/EX.
// PARAMETERS
//  DATA_LENGTH  32    instruction width, bits
//  MEM_SIZE     256   ROM size in bytes; PC width AW = $clog2(MEM_SIZE) = 8
//  RESET_PC     0     PC value loaded on reset (byte address, multiple of 4)
// PORTS
//  clk              in   1            rising-edge clock, the only clock
//  reset            in   1            synchronous, active-high
//  imem_addr        out  AW           byte address to ROM; always equals pc
//  imem_dout        in   DATA_LENGTH  ROM word at imem_addr, combinational, same cycle
//  stall            in   1            hazard stall from ID: hold PC and IF/ID
//  redirect_valid   in   1            taken branch/jump resolved this cycle
//  redirect_target  in   AW           new PC when redirect_valid=1
//  if_id_instr      out  DATA_LENGTH  registered instruction
//  if_id_pc         out  AW           PC of if_id_instr
//  if_id_valid      out  1            if_id_instr is a real instruction, not a bubble
//  fetch_count      out  32           number of instructions delivered valid, wraps
//  fetch_fault      out  1            misaligned redirect seen (see CONFIGURATION)
// BEHAVIOUR
//  Reset, any state, next edge: pc=RESET_PC, if_id_instr=NOP (32'h00000013), if_id_pc=0,
//   if_id_valid=0, fetch_count=0, fetch_fault=0, state=BOOT.
//  FSM states:
//   BOOT: one cycle, no capture, pc unchanged, then RUN. Redirect in BOOT is honoured.
//   RUN: normal fetch.
//   FAULT: only when FETCH_MISALIGN_CHECK_EN is defined.
//  RUN priority per edge: redirect > stall > advance.
//   redirect: pc<=redirect_target; IF/ID <= NOP bubble (valid=0); squashes the in-flight
//    fetch. Redirect during stall is still taken.
//   stall: pc, if_id_* and fetch_count all hold.
//   advance: if_id_instr<=imem_dout, if_id_pc<=pc, if_id_valid<=1, pc<=pc+4,
//    fetch_count<=fetch_count+1.
//  Latency: word at PC p appears on if_id_* one edge after pc==p, when not stalled.
//  Arithmetic: pc+4 is modulo 2**AW, so 8'hFC wraps to 8'h00 with no flag.
//   fetch_count wraps modulo 2**32.
//  Redirect target bits [1:0] are ignored (forced 0) unless CONFIGURATION says otherwise.
//  reset overrides every other input in the same cycle.
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined:
//   RUN + redirect_valid with redirect_target[1:0]!=0 goes to FAULT.
//   FAULT: fetch_fault=1 (sticky), pc frozen, IF/ID holds the NOP bubble with valid=0.
//   Only reset leaves FAULT.
//  Undefined: no FAULT state; low bits are masked; fetch_fault is tied 0.
// STRUCTURE
//  Shared package/defines file riscv_defs: NOP_INSTR, RESET_PC default, state encodings
//  (BOOT=2'd0, RUN=2'd1, FAULT=2'd2).
//  One natural sub-module, pc_reg: PC register plus next-PC mux (redirect/stall/+4).
//  The FSM, IF/ID register and counter live in instruction_fetch.
// TESTING
//  1. reset for 2 cycles, then release -> imem_addr=0x00 for BOOT + 1 cycle. First valid word
//     is mem[0..3] with if_id_pc=0x00, then 0x04, 0x08; fetch_count increments by 1 per fetch.
//  2. stall=1 for 3 cycles at pc=0x10 -> imem_addr stays 0x10, if_id_* and fetch_count frozen.
//     After release, next capture has if_id_pc=0x10.
//  3. redirect_valid=1, target=0x40 at pc=0x14 -> next cycle if_id_valid=0 with NOP and
//     imem_addr=0x40. Following capture has if_id_pc=0x40.
//  4. Free-run from 0xF8 -> if_id_pc sequence 0xF8, 0xFC, 0x00; no fault raised.
//  5. Redirect and stall asserted together, target 0x20 -> redirect wins, pc=0x20, bubble.
//  6. Target 0x22 -> macro defined: fetch_fault=1, pc frozen, valid=0 until reset.
//     Macro undefined: pc=0x20, fetch_fault=0.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared IF-stage definitions: NOP encoding, reset PC default, FSM state codes, next-PC select.
package instruction_fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int          RESET_PC_DEFAULT = 0;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_ADVANCE  = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: ROM address/data, ID/EX control inputs and IF/ID pipeline outputs.
interface instruction_fetch_if #(
  parameter int DATA_LENGTH = 32,
  parameter int AW          = 8
);
  logic [AW-1:0]          imem_addr;
  logic [DATA_LENGTH-1:0] imem_dout;
  logic                   stall;
  logic                   redirect_valid;
  logic [AW-1:0]          redirect_target;
  logic [DATA_LENGTH-1:0] if_id_instr;
  logic [AW-1:0]          if_id_pc;
  logic                   if_id_valid;
  logic [31:0]            fetch_count;
  logic                   fetch_fault;

  modport master (
    output imem_addr, if_id_instr, if_id_pc, if_id_valid, fetch_count, fetch_fault,
    input  imem_dout, stall, redirect_valid, redirect_target
  );

  modport slave (
    input  imem_addr, if_id_instr, if_id_pc, if_id_valid, fetch_count, fetch_fault,
    output imem_dout, stall, redirect_valid, redirect_target
  );
endinterface

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter with next-PC mux; redirect targets are always word-aligned here.
module instruction_fetch_pc_reg
  import instruction_fetch_pkg::*;
#(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  pc_sel_e       i_sel,
  input  logic [AW-1:0] i_target,
  output logic [AW-1:0] o_pc
);

  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_next;

  // +4 wraps naturally at the top of the address space
  always_comb begin
    w_pc_next = r_pc;
    case (i_sel)
      PC_REDIRECT: w_pc_next = i_target & ~AW'(3);
      PC_ADVANCE:  w_pc_next = r_pc + AW'(4);
      default:     w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_pc <= RESET_PC;
    else       r_pc <= w_pc_next;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: BOOT/RUN(/FAULT) FSM, IF/ID register and delivered-instruction counter.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects into a sticky FAULT state.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int DATA_LENGTH = 32,
  parameter int MEM_SIZE    = 256,
  parameter int RESET_PC    = RESET_PC_DEFAULT
) (
  input logic          clk,
  input logic          reset,
  instruction_fetch_if.master bus
);

  localparam int AW = $clog2(MEM_SIZE);

  logic [1:0]             r_state;
  logic [1:0]             w_state_next;
  logic [DATA_LENGTH-1:0] r_instr;
  logic [AW-1:0]          r_if_pc;
  logic                   r_valid;
  logic [31:0]            r_count;
  logic [AW-1:0]          w_pc;
  logic                   w_fault_entry;
  logic                   w_redirect;
  logic                   w_advance;
  pc_sel_e                w_pc_sel;

  always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
    w_fault_entry = (r_state == ST_RUN) && bus.redirect_valid &&
                    is_misaligned(bus.redirect_target[1:0]);
`else
    w_fault_entry = 1'b0;
`endif
    // FAULT ignores everything; a trapped redirect never moves the PC
    w_redirect = bus.redirect_valid && !w_fault_entry &&
                 ((r_state == ST_BOOT) || (r_state == ST_RUN));
    w_advance  = (r_state == ST_RUN) && !bus.redirect_valid && !bus.stall;
    w_pc_sel   = w_redirect ? PC_REDIRECT : (w_advance ? PC_ADVANCE : PC_HOLD);
  end

  always_comb begin
    w_state_next = ST_BOOT;
    case (r_state)
      ST_BOOT:  w_state_next = ST_RUN;
      ST_RUN:   w_state_next = w_fault_entry ? ST_FAULT : ST_RUN;
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_FAULT: w_state_next = ST_FAULT;
`endif
      default:  w_state_next = ST_BOOT;
    endcase
  end

  instruction_fetch_pc_reg #(
    .AW       (AW),
    .RESET_PC (AW'(RESET_PC))
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .i_sel    (w_pc_sel),
    .i_target (bus.redirect_target),
    .o_pc     (w_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_instr <= DATA_LENGTH'(NOP_INSTR);
      r_if_pc <= '0;
      r_valid <= 1'b0;
      r_count <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_fault_entry || w_redirect) begin
        r_instr <= DATA_LENGTH'(NOP_INSTR);
        r_valid <= 1'b0;
      end else if (w_advance) begin
        r_instr <= bus.imem_dout;
        r_if_pc <= w_pc;
        r_valid <= 1'b1;
        r_count <= r_count + 32'd1;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_fault;

  always_ff @(posedge clk) begin
    if (reset)              r_fault <= 1'b0;
    else if (w_fault_entry) r_fault <= 1'b1;
  end

  assign bus.fetch_fault = r_fault;
`else
  assign bus.fetch_fault = 1'b0;
`endif

  assign bus.imem_addr   = w_pc;
  assign bus.if_id_instr = r_instr;
  assign bus.if_id_pc    = r_if_pc;
  assign bus.if_id_valid = r_valid;
  assign bus.fetch_count = r_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; ROM word at byte address a is 32'hC0DE00aa.
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  instruction_fetch_if #(.DATA_LENGTH(32), .AW(8)) bus ();

  instruction_fetch #(
    .DATA_LENGTH (32),
    .MEM_SIZE    (256),
    .RESET_PC    (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_dout = {24'hC0DE00, bus.imem_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One line per transaction: all IF-stage observables against their expected values
  task automatic expect_all(input string tag, input logic [7:0] addr, input logic [31:0] instr,
                            input logic [7:0] pc, input logic valid, input logic [31:0] count,
                            input logic fault);
    $display("%s: addr=%h instr=%h pc=%h valid=%b count=%0d fault=%b", tag, bus.imem_addr,
             bus.if_id_instr, bus.if_id_pc, bus.if_id_valid, bus.fetch_count, bus.fetch_fault);
    check({tag, ".addr"},  32'(bus.imem_addr),   32'(addr));
    check({tag, ".instr"}, bus.if_id_instr,      instr);
    check({tag, ".pc"},    32'(bus.if_id_pc),    32'(pc));
    check({tag, ".valid"}, 32'(bus.if_id_valid), 32'(valid));
    check({tag, ".count"}, bus.fetch_count,      count);
    check({tag, ".fault"}, 32'(bus.fetch_fault), 32'(fault));
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    reset               = 1'b1;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 8'h00;

    tick();
    tick();
    expect_all("reset", 8'h00, NOP, 8'h00, 1'b0, 0, 1'b0);
    reset = 1'b0;

    tick();
    expect_all("boot", 8'h00, NOP, 8'h00, 1'b0, 0, 1'b0);
    tick();
    expect_all("fetch0", 8'h04, 32'hC0DE0000, 8'h00, 1'b1, 1, 1'b0);
    tick();
    expect_all("fetch4", 8'h08, 32'hC0DE0004, 8'h04, 1'b1, 2, 1'b0);
    tick();
    expect_all("fetch8", 8'h0C, 32'hC0DE0008, 8'h08, 1'b1, 3, 1'b0);
    tick();
    expect_all("fetchC", 8'h10, 32'hC0DE000C, 8'h0C, 1'b1, 4, 1'b0);

    bus.stall = 1'b1;
    tick();
    expect_all("stall1", 8'h10, 32'hC0DE000C, 8'h0C, 1'b1, 4, 1'b0);
    tick();
    expect_all("stall2", 8'h10, 32'hC0DE000C, 8'h0C, 1'b1, 4, 1'b0);
    tick();
    expect_all("stall3", 8'h10, 32'hC0DE000C, 8'h0C, 1'b1, 4, 1'b0);
    bus.stall = 1'b0;
    tick();
    expect_all("unstall", 8'h14, 32'hC0DE0010, 8'h10, 1'b1, 5, 1'b0);

    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 8'h40;
    tick();
    expect_all("redir40", 8'h40, NOP, 8'h10, 1'b0, 5, 1'b0);
    bus.redirect_valid = 1'b0;
    tick();
    expect_all("fetch40", 8'h44, 32'hC0DE0040, 8'h40, 1'b1, 6, 1'b0);

    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 8'hF8;
    tick();
    expect_all("redirF8", 8'hF8, NOP, 8'h40, 1'b0, 6, 1'b0);
    bus.redirect_valid = 1'b0;
    tick();
    expect_all("fetchF8", 8'hFC, 32'hC0DE00F8, 8'hF8, 1'b1, 7, 1'b0);
    tick();
    expect_all("fetchFC", 8'h00, 32'hC0DE00FC, 8'hFC, 1'b1, 8, 1'b0);
    tick();
    expect_all("wrap00", 8'h04, 32'hC0DE0000, 8'h00, 1'b1, 9, 1'b0);

    bus.stall           = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 8'h20;
    tick();
    expect_all("redirStall", 8'h20, NOP, 8'h00, 1'b0, 9, 1'b0);
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    tick();
    expect_all("fetch20", 8'h24, 32'hC0DE0020, 8'h20, 1'b1, 10, 1'b0);

    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 8'h22;
    tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    expect_all("misalign", 8'h24, NOP, 8'h20, 1'b0, 10, 1'b1);
    bus.redirect_valid = 1'b0;
    tick();
    expect_all("faultHold", 8'h24, NOP, 8'h20, 1'b0, 10, 1'b1);
`else
    expect_all("misalign", 8'h20, NOP, 8'h20, 1'b0, 10, 1'b0);
    bus.redirect_valid = 1'b0;
    tick();
    expect_all("fetchMask", 8'h24, 32'hC0DE0020, 8'h20, 1'b1, 11, 1'b0);
`endif

    reset               = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 8'h80;
    tick();
    expect_all("resetWins", 8'h00, NOP, 8'h00, 1'b0, 0, 1'b0);

    reset               = 1'b0;
    bus.redirect_target = 8'h30;
    tick();
    expect_all("bootRedir", 8'h30, NOP, 8'h00, 1'b0, 0, 1'b0);
    bus.redirect_valid = 1'b0;
    tick();
    expect_all("fetch30", 8'h34, 32'hC0DE0030, 8'h30, 1'b1, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
